// File: rtl/hist_readout.sv
`default_nettype none
// ============================================================================
// Module  : hist_readout
// Brief   : Freezes the histogrammer, scans every RAM bin and streams a framed
//           byte sequence (header, MSB/LSB per bin, XOR checksum) to a UART TX.
// Rev     : 1.0  initial release
// ============================================================================
module hist_readout #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 1024,
    parameter int CLEAR_ON_READ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  hist_hold,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  ram_wr_en,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam logic [7:0]            c_HDR0      = 8'hA5;
    localparam logic [7:0]            c_HDR1      = 8'h5A;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_HDR0      = 4'd1,
        S_HDR1      = 4'd2,
        S_RD_ADDR   = 4'd3,
        S_RD_WAIT   = 4'd4,
        S_SEND_MSB  = 4'd5,
        S_SEND_LSB  = 4'd6,
        S_CLEAR     = 4'd7,
        S_NEXT      = 4'd8,
        S_SEND_CSUM = 4'd9,
        S_DONE      = 4'd10
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_buf;
    logic [7:0]            r_csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // tx_data/tx_valid are pure functions of state and the registered buffer,
    // so they stay stable for as long as the transmitter stalls.
    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        ram_wr_en = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_HDR0;
                end
            end
            S_HDR0: begin
                tx_valid = 1'b1;
                tx_data  = c_HDR0;
                if (tx_ready) begin
                    w_next = S_HDR1;
                end
            end
            S_HDR1: begin
                tx_valid = 1'b1;
                tx_data  = c_HDR1;
                if (tx_ready) begin
                    w_next = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                w_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_next = S_SEND_MSB;
            end
            S_SEND_MSB: begin
                tx_valid = 1'b1;
                tx_data  = r_buf[DATA_WIDTH-1 -: 8];
                if (tx_ready) begin
                    w_next = S_SEND_LSB;
                end
            end
            S_SEND_LSB: begin
                tx_valid = 1'b1;
                tx_data  = r_buf[7:0];
                if (tx_ready) begin
                    w_next = (CLEAR_ON_READ != 0) ? S_CLEAR : S_NEXT;
                end
            end
            S_CLEAR: begin
                ram_wr_en = 1'b1;
                w_next    = S_NEXT;
            end
            S_NEXT: begin
                w_next = (r_addr == c_LAST_ADDR) ? S_SEND_CSUM : S_RD_ADDR;
            end
            S_SEND_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = r_csum;
                if (tx_ready) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy   = 1'b0;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_buf  <= '0;
            r_csum <= 8'h00;
        end else begin
            case (r_state)
                S_HDR1: begin
                    if (tx_ready) begin
                        r_csum <= 8'h00;
                        r_addr <= '0;
                    end
                end
                S_RD_WAIT: begin
                    r_buf <= ram_rd_data;
                end
                S_SEND_MSB: begin
                    if (tx_ready) begin
                        r_csum <= r_csum ^ r_buf[DATA_WIDTH-1 -: 8];
                    end
                end
                S_SEND_LSB: begin
                    if (tx_ready) begin
                        r_csum <= r_csum ^ r_buf[7:0];
                    end
                end
                S_NEXT: begin
                    // Saturate at the last bin; the address is left there after DONE.
                    if (r_addr != c_LAST_ADDR) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ram_addr    = r_addr;
    assign hist_hold   = busy;
    assign ram_wr_data = '0;

endmodule
`default_nettype wire

// File: tb/tb_hist_readout.sv
`default_nettype none
// ============================================================================
// Module  : tb_hist_readout
// Brief   : Checks two readout instances (with and without clear-on-read)
//           against a frame model built from RAM snapshots.
// Rev     : 1.0  initial release
// ============================================================================
module tb_hist_readout;

    localparam int DEPTH = 4;
    localparam int AW    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       tx_ready;
    logic       load_en;
    logic [1:0] busy, hold, done, wr_en, tx_valid;
    logic [AW-1:0] addr    [2];
    logic [15:0]   rd_data [2];
    logic [15:0]   wr_data [2];
    logic [7:0]    tx_data [2];

    logic [15:0] ram      [2][DEPTH];
    logic [15:0] load_val [2][DEPTH];
    logic [15:0] snap     [2][DEPTH];
    logic [15:0] pat      [DEPTH];
    logic [7:0]  lit      [11];

    int          checks;
    int          errors;
    logic [7:0]  exp_mem [2][16];
    int          exp_len [2];
    int          ptr [2];
    int          wr_idx [2];
    int          bcnt [2];
    int          done_cnt [2];
    bit          armed [2];
    bit          stall [2];
    bit          wr_prev [2];
    logic [7:0]  stall_data [2];
    bit          full_rate;

    hist_readout #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .DEPTH(DEPTH), .CLEAR_ON_READ(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy[0]), .hist_hold(hold[0]),
        .done(done[0]), .ram_addr(addr[0]), .ram_rd_data(rd_data[0]), .ram_wr_en(wr_en[0]),
        .ram_wr_data(wr_data[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready)
    );

    hist_readout #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .DEPTH(DEPTH), .CLEAR_ON_READ(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy[1]), .hist_hold(hold[1]),
        .done(done[1]), .ram_addr(addr[1]), .ram_rd_data(rd_data[1]), .ram_wr_en(wr_en[1]),
        .ram_wr_data(wr_data[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready)
    );

    // Synchronous RAM model, 1-cycle read latency, one per instance.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (load_en) begin
                for (int i = 0; i < DEPTH; i++) ram[d][i] <= load_val[d][i];
            end else if (wr_en[d]) begin
                ram[d][addr[d][1:0]] <= wr_data[d];
            end
            rd_data[d] <= ram[d][addr[d][1:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic monitor();
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                ptr[d] = 0; armed[d] = 0; wr_idx[d] = 0; bcnt[d] = 0;
                stall[d] = 0; wr_prev[d] = 0;
            end
            return;
        end
        for (int d = 0; d < 2; d++) begin
            chk("hold_eq_busy", 32'(hold[d]), 32'(busy[d]));
            chk("wr_data_zero", 32'(wr_data[d]), 32'd0);
            if (!armed[d]) begin
                chk("idle_quiet", {28'd0, busy[d], done[d], tx_valid[d], wr_en[d]}, 32'd0);
            end else begin
                if (busy[d]) bcnt[d]++;
                chk("addr_range", 32'({29'd0, addr[d]} <= 32'(DEPTH - 1)), 32'd1);
                if (stall[d]) begin
                    chk("stall_valid", 32'(tx_valid[d]), 32'd1);
                    chk("stall_data", 32'(tx_data[d]), 32'(stall_data[d]));
                end
                if (tx_valid[d] && tx_ready) begin
                    if (ptr[d] < exp_len[d]) chk("byte", 32'(tx_data[d]), 32'(exp_mem[d][ptr[d]]));
                    else chk("xfer_count", 32'(ptr[d] + 1), 32'(exp_len[d]));
                    ptr[d]++;
                end
                stall[d]      = tx_valid[d] && !tx_ready;
                stall_data[d] = tx_data[d];
                if (wr_en[d]) begin
                    chk("wr_allowed", 32'd1, 32'(d));
                    chk("wr_addr", 32'(addr[d]), 32'(wr_idx[d]));
                    chk("wr_single", 32'(wr_prev[d]), 32'd0);
                    wr_idx[d]++;
                end
                wr_prev[d] = wr_en[d];
                if (done[d]) begin
                    chk("done_busy_low", 32'(busy[d]), 32'd0);
                    chk("done_all_bytes", 32'(ptr[d]), 32'(exp_len[d]));
                    if (d == 1) chk("clear_count", 32'(wr_idx[d]), 32'(DEPTH));
                    if (full_rate) chk("dump_cycles", 32'(bcnt[d]), 32'(3 + DEPTH * (5 + d)));
                    done_cnt[d]++;
                    armed[d] = 0; ptr[d] = 0; wr_idx[d] = 0; bcnt[d] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; start = 1'b1; tx_ready = 1'b1;
        repeat (n) tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_hold", 32'(hold[d]), 32'd0);
            chk("rst_done", 32'(done[d]), 32'd0);
            chk("rst_addr", 32'(addr[d]), 32'd0);
            chk("rst_wr_en", 32'(wr_en[d]), 32'd0);
            chk("rst_wr_data", 32'(wr_data[d]), 32'd0);
            chk("rst_tx_valid", 32'(tx_valid[d]), 32'd0);
            chk("rst_tx_data", 32'(tx_data[d]), 32'd0);
        end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic load_ram(input bit rnd);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                load_val[d][i] = rnd ? 16'($urandom) : pat[i];
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
    endtask

    // Expected frame straight from the frame rules applied to a RAM snapshot.
    task automatic arm_frame();
        logic [7:0] cs;
        for (int d = 0; d < 2; d++) begin
            cs = 8'h00;
            exp_mem[d][0] = 8'hA5;
            exp_mem[d][1] = 8'h5A;
            for (int i = 0; i < DEPTH; i++) begin
                snap[d][i]            = ram[d][i];
                exp_mem[d][2 + 2 * i] = ram[d][i][15:8];
                exp_mem[d][3 + 2 * i] = ram[d][i][7:0];
                cs = cs ^ ram[d][i][15:8] ^ ram[d][i][7:0];
            end
            exp_mem[d][2 + 2 * DEPTH] = cs;
            exp_len[d] = 3 + 2 * DEPTH;
            armed[d] = 1; ptr[d] = 0; wr_idx[d] = 0; bcnt[d] = 0;
            stall[d] = 0; wr_prev[d] = 0;
        end
    endtask

    task automatic run_dump(input int mode, input bit midstart);
        int d0, d1;
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        full_rate = (mode == 0);
        arm_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (done_cnt[0] != d0 && done_cnt[1] != d1) break;
            tx_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
            start    = midstart && (c == 10);
            tick();
        end
        start = 1'b0;
        tx_ready = 1'b1;
        repeat (6) tick();
        chk("done_pulses0", 32'(done_cnt[0] - d0), 32'd1);
        chk("done_pulses1", 32'(done_cnt[1] - d1), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("ram_kept", 32'(ram[0][i]), 32'(snap[0][i]));
            chk("ram_cleared", 32'(ram[1][i]), 32'd0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, d1;
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; tx_ready = 1'b1; load_en = 1'b0; full_rate = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ptr[d] = 0; armed[d] = 0; wr_idx[d] = 0; bcnt[d] = 0; done_cnt[d] = 0;
            stall[d] = 0; wr_prev[d] = 0; exp_len[d] = 0; stall_data[d] = 8'h00;
        end
        pat = '{16'h0001, 16'h1234, 16'hFFFF, 16'h0000};
        lit = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h12, 8'h34, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h27};

        do_reset(3);

        // Fixed pattern at full rate; model pinned to the hand-built frame.
        load_ram(1'b0);
        run_dump(0, 1'b0);
        chk("model_len", 32'(exp_len[0]), 32'd11);
        for (int k = 0; k < 11; k++) chk("model_pin", 32'(exp_mem[0][k]), 32'(lit[k]));

        // Same pattern under heavy backpressure, with a start pulse mid-dump.
        load_ram(1'b0);
        run_dump(1, 1'b1);

        // Instance 1 was cleared; its next frame must be all zero bytes.
        run_dump(0, 1'b0);
        for (int k = 2; k < 11; k++) chk("model_pin_zero", 32'(exp_mem[1][k]), 32'd0);

        for (int r = 0; r < 4; r++) begin
            load_ram(1'b1);
            run_dump(r % 2, r == 1);
        end

        // Reset while instance 0 presents the LSB of bin 1.
        load_ram(1'b0);
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        full_rate = 1'b0;
        arm_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (ptr[0] == 5 && tx_valid[0]) break;
            tx_ready = 1'b1;
            tick();
        end
        chk("lsb1_reached", 32'(ptr[0]), 32'd5);
        do_reset(2);
        repeat (4) tick();
        chk("abort_no_done0", 32'(done_cnt[0]), 32'(d0));
        chk("abort_no_done1", 32'(done_cnt[1]), 32'(d1));
        run_dump(1, 1'b0);
        run_dump(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
